// File: rtl/pixel_shift_buffer.sv
// Double-buffered pixel serialiser: a one-byte holding register feeds a
// shifter that emits 1/2/4-bit colour codes MSB-first. Each pixel is stretched
// by a programmable divider, and an empty shifter with no waiting byte is
// flagged as an underrun.
module pixel_shift_buffer #(
  parameter int DATA_W  = 8,
  parameter int MAX_BPP = 4,
  parameter int DIV_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [1:0]         bpp_sel,
  input  logic [DIV_W-1:0]   pix_div,
  output logic [MAX_BPP-1:0] pix,
  output logic               pix_valid,
  output logic               underrun,
  output logic               underrun_st
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {BPP1, BPP2, BPP4} bpp_t;

  // Holding register
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;

  // Shifter
  logic [DATA_W-1:0] sh_data;
  bpp_t              sh_bpp;
  logic [DIV_W-1:0]  sh_div;
  logic [CNT_W-1:0]  px_left;
  logic [DIV_W-1:0]  div_cnt;

  // Combinational helpers
  bpp_t              bpp_dec;
  logic [CNT_W-1:0]  px_per_byte;
  logic [DATA_W-1:0] sh_shifted;
  logic [3:0]        pix_raw;
  logic              active;
  logic              step;
  logic              finishing;
  logic              transfer;

  assign active    = (px_left != '0);
  assign step      = active && (div_cnt == sh_div);
  assign finishing = step && (px_left == CNT_W'(1));
  // The shifter only takes a new byte when idle or on its final pixel clock.
  assign transfer  = enable && hold_full && (!active || finishing);

  // Decode the requested pixel depth; 4bpp only exists for 4-bit colour codes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    bpp_dec     = BPP1;
    px_per_byte = CNT_W'(DATA_W);
    case (bpp_sel)
      2'b01: begin
        bpp_dec     = BPP2;
        px_per_byte = CNT_W'(DATA_W / 2);
      end
      2'b10: begin
        if (MAX_BPP == 4) begin
          bpp_dec     = BPP4;
          px_per_byte = CNT_W'(DATA_W / 4);
        end
      end
      default: ;
    endcase
  end

  // Select the current top pixel and the shifted-up data for the next pixel.
  always_comb begin
    pix_raw    = 4'd0;
    sh_shifted = sh_data;
    case (sh_bpp)
      BPP1: begin
        pix_raw    = {3'd0, sh_data[DATA_W-1]};
        sh_shifted = {sh_data[DATA_W-2:0], 1'b0};
      end
      BPP2: begin
        pix_raw    = {2'd0, sh_data[DATA_W-1 -: 2]};
        sh_shifted = {sh_data[DATA_W-3:0], 2'b00};
      end
      BPP4: begin
        pix_raw    = sh_data[DATA_W-1 -: 4];
        sh_shifted = {sh_data[DATA_W-5:0], 4'h0};
      end
      default: ;
    endcase
  end

  assign pix_valid = active;
  assign pix       = active ? pix_raw[MAX_BPP-1:0] : '0;

  // Holding register and ready handshake; keeps running while blanked.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers
    // see the same pre-edge values.
    if (reset) begin
      hold_full  <= 1'b0;
      load_ready <= 1'b1;
    end else if (transfer) begin
      hold_full  <= 1'b0;
      load_ready <= 1'b1;
    end else if (load_valid && load_ready) begin
      hold_full  <= 1'b1;
      load_ready <= 1'b0;
    end
  end

  // Capture accepted bytes.
  always_ff @(posedge clk) begin
    // NOTE: pure data registers are not reset; the full/count flags gate them.
    if (load_valid && load_ready && !transfer) begin
      hold_data <= in_data;
    end
  end

  // Shifter control: counters, byte transfer, flush on blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      px_left <= '0;
      div_cnt <= '0;
      sh_bpp  <= BPP1;
      sh_div  <= '0;
    end else if (!enable) begin
      px_left <= '0;
      div_cnt <= '0;
    end else if (transfer) begin
      px_left <= px_per_byte;
      div_cnt <= '0;
      sh_bpp  <= bpp_dec;
      sh_div  <= pix_div;
    end else if (step) begin
      px_left <= px_left - CNT_W'(1);
      div_cnt <= '0;
    end else if (active) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Shifter data path.
  always_ff @(posedge clk) begin
    if (transfer) begin
      sh_data <= hold_data;
    end else if (enable && step) begin
      sh_data <= sh_shifted;
    end
  end

  // Underrun pulse and sticky flag: last pixel ended with nothing waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun    <= 1'b0;
      underrun_st <= 1'b0;
    end else begin
      underrun <= enable && finishing && !hold_full;
      if (enable && finishing && !hold_full) begin
        underrun_st <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_shift_buffer.sv
// Bench for pixel_shift_buffer: directed byte loads with hand-listed expected
// pixel streams pushed into a scoreboard queue; a monitor pops and compares
// every cycle the DUT presents pix_valid.
module tb_pixel_shift_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] in_data;
  logic       load_valid;
  logic       load_ready;
  logic [1:0] bpp_sel;
  logic [1:0] pix_div;
  logic [3:0] pix;
  logic       pix_valid;
  logic       underrun;
  logic       underrun_st;

  int checks = 0;
  int errors = 0;
  int und_cnt = 0;
  int und_base;

  logic [3:0] exp_q[$];
  logic [3:0] exp_list[$];

  pixel_shift_buffer #(.DATA_W(8), .MAX_BPP(4), .DIV_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_data    (in_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .bpp_sel    (bpp_sel),
    .pix_div    (pix_div),
    .pix        (pix),
    .pix_valid  (pix_valid),
    .underrun   (underrun),
    .underrun_st(underrun_st)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every valid pixel against the scoreboard, count underrun cycles.
  always @(negedge clk) begin : monitor
    logic [3:0] e;
    if (underrun === 1'b1) und_cnt++;
    if (pix_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: got %0h expected no pixel", pix);
      end else begin
        e = exp_q.pop_front();
        if (pix !== e) begin
          errors++;
          $display("FAIL pix_stream: got %0h expected %0h", pix, e);
        end
      end
    end
  end

  task automatic push_seq(input int reps);
    foreach (exp_list[i]) repeat (reps) exp_q.push_back(exp_list[i]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait for ready (bounded), then present one byte for a single accepting edge.
  task automatic send(input logic [7:0] d);
    int n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=%0b expected 1", load_ready);
    end
    in_data    = d;
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
  endtask

  // Length of the next contiguous run of pix_valid cycles.
  task automatic wait_run(input string name, input int exp_len);
    int n = 0;
    int w = 0;
    while (pix_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    while (pix_valid === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n, exp_len);
  endtask

  task automatic check_underruns(input string name, input int exp_n);
    tick(3);
    check(name, und_cnt - und_base, exp_n);
    und_base = und_cnt;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; load_valid = 1'b0; in_data = 8'h00;
    bpp_sel = 2'b00; pix_div = 2'd0;
    tick(3);
    check("rst_load_ready", load_ready, 1);
    check("rst_pix", pix, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_underrun_st", underrun_st, 0);
    reset = 1'b0;
    tick(1);
    und_base = und_cnt;

    // 1) 1bpp, div 0, 8'hA5 into idle shifter, then underrun.
    exp_list = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1};
    push_seq(1);
    send(8'hA5);
    wait_run("t1_run", 8);
    check_underruns("t1_underrun", 1);
    check("t1_underrun_st", underrun_st, 1);
    check("t1_pix_idle", pix, 0);

    // 2) 2bpp, div 1, 8'h1B: each pixel held two clocks.
    bpp_sel = 2'b01; pix_div = 2'd1;
    exp_list = '{4'd0, 4'd1, 4'd2, 4'd3};
    push_seq(2);
    send(8'h1B);
    wait_run("t2_run", 8);
    check_underruns("t2_underrun", 1);

    // 3) 4bpp, C3 then 5A while busy: four contiguous pixels.
    bpp_sel = 2'b10; pix_div = 2'd0;
    exp_list = '{4'hC, 4'h3, 4'h5, 4'hA};
    push_seq(1);
    fork
      wait_run("t3_run_no_gap", 4);
      begin
        send(8'hC3);
        send(8'h5A);
      end
    join
    check_underruns("t3_underrun", 1);

    // 4) bpp_sel changes mid-byte: 96 at 1bpp, 6C at 2bpp.
    bpp_sel = 2'b00; pix_div = 2'd0;
    exp_list = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    push_seq(1);
    fork
      wait_run("t4_run", 12);
      begin
        send(8'h96);
        tick(1);
        bpp_sel = 2'b01;
        send(8'h6C);
      end
    join
    check_underruns("t4_underrun", 1);

    // 5) load_valid held high through hold-full stalls; order preserved.
    bpp_sel = 2'b01; pix_div = 2'd0;
    exp_list = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0, 4'd3};
    push_seq(1);
    fork
      wait_run("t5_run", 12);
      begin
        in_data = 8'h11; load_valid = 1'b1;
        tick(1);
        check("t5_ready_after_accept", load_ready, 0);
        in_data = 8'h22;
        tick(1);
        check("t5_ready_after_transfer", load_ready, 1);
        tick(1);
        check("t5_ready_hold_full", load_ready, 0);
        in_data = 8'h33;
        tick(1);
        check("t5_ready_still_full", load_ready, 0);
        for (int i = 0; i < 20 && load_ready !== 1'b1; i++) tick(1);
        tick(1);
        load_valid = 1'b0;
      end
    join
    check_underruns("t5_underrun", 1);

    // 6a) Drop enable mid-byte: output blanks next clock, no underrun.
    bpp_sel = 2'b00; pix_div = 2'd0;
    exp_list = '{4'd1, 4'd1, 4'd1};
    push_seq(1);
    send(8'hFF);
    tick(3);
    enable = 1'b0;
    tick(1);
    check("t6_blank_valid", pix_valid, 0);
    check("t6_blank_pix", pix, 0);
    check_underruns("t6_blank_underrun", 0);
    check("t6_sticky_kept", underrun_st, 1);

    // 6b) Preload during blanking, transfer on first enabled edge.
    send(8'h80);
    tick(2);
    check("t6_preload_ready", load_ready, 0);
    check("t6_preload_blank", pix_valid, 0);
    exp_list = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    push_seq(1);
    enable = 1'b1;
    wait_run("t6_preload_run", 8);
    check_underruns("t6_preload_underrun", 1);

    // 6c) Reset mid-byte discards the byte and clears the sticky flag.
    exp_list = '{4'd1, 4'd1};
    push_seq(1);
    send(8'hFF);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("t6_rst_valid", pix_valid, 0);
    check("t6_rst_sticky", underrun_st, 0);
    check("t6_rst_ready", load_ready, 1);
    check("t6_rst_underrun", underrun, 0);
    reset = 1'b0;
    check_underruns("t6_rst_no_underrun", 0);
    check("t6_rst_sticky_stays", underrun_st, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
